// File: rtl/mem_stage_if.sv
// Bundle between the execute stage, the data memory and the writeback stage
// around mem_stage. The slave modport is the mem_stage view; the master
// modport is the surrounding pipeline/memory view.
// Optional macro MEM_MISALIGN_EXC_EN adds the misalign_exc signal.
interface mem_stage_if;
  // Execute-stage side
  logic        in_valid;
  logic [31:0] in_opr_res;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic [1:0]  in_wb_sel;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_mem_op;
  logic        mem_stall;
  // Data memory side
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        bus_err;
`ifdef MEM_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif
  // Writeback side
  logic [31:0] out_opr_res;
  logic [31:0] out_dmem_rdata;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [1:0]  out_wb_sel;

  modport slave (
    input  in_valid, in_opr_res, in_store_data, in_rd, in_wb_en, in_wb_sel,
    input  in_mem_read, in_mem_write, in_mem_op,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
`ifdef MEM_MISALIGN_EXC_EN
    output misalign_exc,
`endif
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, bus_err,
    output out_opr_res, out_dmem_rdata, out_rd, out_wb_en, out_wb_sel
  );

  modport master (
    output in_valid, in_opr_res, in_store_data, in_rd, in_wb_en, in_wb_sel,
    output in_mem_read, in_mem_write, in_mem_op,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
`ifdef MEM_MISALIGN_EXC_EN
    input  misalign_exc,
`endif
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, bus_err,
    input  out_opr_res, out_dmem_rdata, out_rd, out_wb_en, out_wb_sel
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Issues loads/stores over a req/gnt/rvalid bus, lane-shifts store data,
// extracts and extends load data, and registers the writeback fields.
// A transaction stuck in WAIT_GNT/WAIT_RSP for RSP_TIMEOUT cycles is aborted
// with a one-cycle bus_err pulse.
// Optional macro MEM_MISALIGN_EXC_EN: misaligned halfword/word accesses are
// dropped and flagged on misalign_exc instead of being forced aligned.
module mem_stage #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        arst_n,
  mem_stage_if.slave  bus
);

  localparam int CNT_W = (RSP_TIMEOUT < 1) ? 1 : $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // Byte enables for a store/load of the given size at the given lane offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so every offset sees its bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic        [31:0] sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    sh  = rdata >> {off, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    case (op)
      3'b000:  r_s = 32'(b_s);
      3'b001:  r_s = 32'(h_s);
      3'b100:  r_s = {24'd0, sh[7:0]};
      3'b101:  r_s = {16'd0, sh[15:0]};
      default: r_s = sh;
    endcase
    return r_s;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      out_opr_res_q;
  logic [31:0]      out_dmem_rdata_q;
  logic [4:0]       out_rd_q;
  logic             out_wb_en_q;
  logic [1:0]       out_wb_sel_q;
  logic             bus_err_q;

  logic [1:0] size;
  logic [1:0] raw_off;
  logic [1:0] off;
  logic       is_mem;
  logic       is_load;
  logic       mis_drop;
  logic       timeout;
  logic       req;
  logic       stall;
  logic       done;
  logic       abort;

  // A simultaneous read+write is a load; size code 11 behaves as a word.
  assign size    = bus.in_mem_op[1:0];
  assign raw_off = bus.in_opr_res[1:0];
  assign is_mem  = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
  assign is_load = bus.in_mem_read;

  // Halfwords may only sit on even lanes and words on lane 0, so the
  // misalignment bits are forced to zero for the lane/extract logic.
  assign off = (size == 2'b00) ? raw_off :
               (size == 2'b01) ? {raw_off[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_EXC_EN
  logic misaligned;
  logic misalign_exc_q;
  assign misaligned       = (size == 2'b01) ? raw_off[0] :
                            (size == 2'b00) ? 1'b0 : (raw_off != 2'b00);
  assign mis_drop         = is_mem & misaligned;
  assign bus.misalign_exc = misalign_exc_q;
`else
  assign mis_drop = 1'b0;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(RSP_TIMEOUT));

  // Per-state request/stall/completion decode; gnt and rvalid win over timeout.
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (!is_mem) begin
            done = 1'b1;
          end else if (!mis_drop) begin
            req = 1'b1;
            if (bus.dmem_gnt && !is_load) done  = 1'b1;
            else                          stall = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (bus.dmem_gnt) begin
          if (!is_load) done  = 1'b1;
          else          stall = 1'b1;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (bus.dmem_rvalid) done  = 1'b1;
        else if (timeout)    abort = 1'b1;
        else                 stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_stall  = stall;
  assign bus.dmem_req   = req;
  assign bus.dmem_we    = req & ~bus.in_mem_read;
  assign bus.dmem_addr  = {bus.in_opr_res[31:2], 2'b00};
  assign bus.dmem_be    = req ? lane_be(size, off) : 4'b0000;
  assign bus.dmem_wdata = lane_wdata(size, bus.in_store_data);

  // FSM, timeout counter and registered writeback fields; every edge without
  // a completing instruction registers a bubble (out_wb_en=0).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      out_opr_res_q    <= '0;
      out_dmem_rdata_q <= '0;
      out_rd_q         <= '0;
      out_wb_en_q      <= 1'b0;
      out_wb_sel_q     <= '0;
      bus_err_q        <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      misalign_exc_q   <= 1'b0;
`endif
    end else begin
      bus_err_q   <= abort;
      out_wb_en_q <= done & bus.in_wb_en;
`ifdef MEM_MISALIGN_EXC_EN
      misalign_exc_q <= (state_q == IDLE) & mis_drop;
`endif
      if (done) begin
        out_opr_res_q <= bus.in_opr_res;
        out_rd_q      <= bus.in_rd;
        out_wb_sel_q  <= bus.in_wb_sel;
        if (state_q == WAIT_RSP) begin
          out_dmem_rdata_q <= load_extend(bus.in_mem_op, off, bus.dmem_rdata);
        end
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req && !(bus.dmem_gnt && !is_load)) begin
            state_q <= bus.dmem_gnt ? WAIT_RSP : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (bus.dmem_gnt) begin
            state_q <= is_load ? WAIT_RSP : IDLE;
            cnt_q   <= '0;
          end else if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        WAIT_RSP: begin
          if (bus.dmem_rvalid || abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.out_opr_res    = out_opr_res_q;
  assign bus.out_dmem_rdata = out_dmem_rdata_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_wb_en      = out_wb_en_q;
  assign bus.out_wb_sel     = out_wb_sel_q;
  assign bus.bus_err        = bus_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between execute and writeback.
- Issues loads/stores to the data memory over a req/gnt/rvalid bus, aligns and sign/zero-extends load data, and applies byte enables and lane shifting to stores.
- Registers the opr_res, dmem_rdata, rd, wb_en and wb_sel fields that the writeback stage consumes.
- Stalls the front of the pipe while a memory transaction is outstanding.

Parameters:
- RSP_TIMEOUT, 255, max cycles waited in WAIT_GNT or WAIT_RSP before the access is aborted; counter width is clog2(RSP_TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction from EX is valid
- in_opr_res  in  32  ALU result; also the memory address
- in_store_data  in  32  rs2 value for stores
- in_rd  in  5  destination register
- in_wb_en  in  1  register write enable
- in_wb_sel  in  2  writeback mux select; passed through unchanged
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_stall  out  1  hold EX/earlier stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  raw read word
- bus_err  out  1  one-cycle pulse on timeout abort
- out_opr_res  out  32  to WB
- out_dmem_rdata  out  32  extended load data to WB
- out_rd  out  5  to WB
- out_wb_en  out  1  to WB
- out_wb_sel  out  2  to WB

Behaviour:
- Reset (async, arst_n=0):
  - State IDLE; timeout counter 0.
  - All out_* 0; mem_stall, dmem_req, dmem_we, bus_err 0.
  - Reset mid-transaction drops it; a later dmem_rvalid is ignored in IDLE.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
- IDLE:
  - in_valid with neither mem_read nor mem_write: pass-through, latency 1; out_* registered next edge.
  - in_valid with a memory op: dmem_req=1 combinationally.
    - gnt same cycle, store: complete; registered next edge; stay IDLE.
    - gnt same cycle, load: go to WAIT_RSP; mem_stall=1.
    - No gnt: go to WAIT_GNT; mem_stall=1.
- WAIT_GNT:
  - dmem_req held high; addr/we/be/wdata stable (upstream holds inputs while mem_stall).
  - On gnt: store completes and returns to IDLE; load goes to WAIT_RSP.
- WAIT_RSP:
  - dmem_req=0; mem_stall=1 until the dmem_rvalid cycle.
  - On rvalid: mem_stall=0 that cycle; extended data registered into out_dmem_rdata at the edge; back to IDLE.
- Response rules:
  - rvalid arrives at the earliest one cycle after gnt.
  - rvalid in IDLE or WAIT_GNT is ignored.
- Bubble rule: every edge where no instruction completes (stall cycle or in_valid=0) registers out_wb_en=0; other out_* hold. Writeback never repeats.
- Timeout:
  - Counter clears on entry to WAIT_GNT/WAIT_RSP and increments each cycle there.
  - On reaching RSP_TIMEOUT: return to IDLE, pulse bus_err, register out_wb_en=0, deassert mem_stall.
- Store lanes (off=addr[1:0]):
  - B: be = 0001<<off; wdata = {4{data[7:0]}}.
  - H: be = 0011<<off; wdata = {2{data[15:0]}}.
  - W: be = 1111; wdata = data.
- Load extraction:
  - Byte = rdata >> (8*off).
  - B/H sign-extend; BU/HU zero-extend; W raw.
- Misaligned:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Handling depends on the optional feature below.
- Simultaneous in_mem_read and in_mem_write: treated as a load.

Optional Feature:
- Macro MEM_MISALIGN_EXC_EN.
- Defined:
  - Adds output misalign_exc (1 bit).
  - A misaligned access issues no request and pulses misalign_exc for one cycle.
  - Registers out_wb_en=0; no stall.
- Undefined:
  - The misalignment bits are forced to zero (H: addr[0]; W: addr[1:0]).
  - The access proceeds aligned; no exception port.

Test Plan:
- ADD pass-through: opr_res=0x1234, rd=5, wb_en=1 -> next cycle out_opr_res=0x1234, out_rd=5, out_wb_en=1; dmem_req never asserted.
- LB at 0x1003, rdata=0x80FF_FF00, gnt same cycle, rvalid next cycle -> out_dmem_rdata=0xFFFF_FF80; mem_stall high exactly 1 cycle.
- LHU at 0x2002, rdata=0xBEEF_0000 -> out_dmem_rdata=0x0000_BEEF.
- SB at 0x3001, store_data=0xAB, gnt delayed 3 cycles -> dmem_be=0010, dmem_wdata=0xABAB_ABAB, mem_stall 3 cycles, 3 bubbles with out_wb_en=0, then dmem_req drops.
- Load with no rvalid and RSP_TIMEOUT=4 -> bus_err pulses after 4 WAIT_RSP cycles; out_wb_en=0; FSM back in IDLE.
- LW at 0x4002:
  - MEM_MISALIGN_EXC_EN defined -> misalign_exc pulse, no dmem_req.
  - Undefined -> dmem_addr=0x4000, be=1111.
